// File: rtl/aes_inv_sub_bytes.sv
// Registered AES InvSubBytes stage for the inverse-cipher datapath.
// Each of the 16 state bytes passes through its own inverse S-box lookup.
// The result is presented one clock after the input is accepted.
module aes_inv_sub_bytes (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] state,
  output logic [127:0] state_out,
  output logic         out_valid
);

  // FIPS-197 inverse S-box, stored as a constant ROM indexed by byte value.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Single-byte inverse substitution; every index is a defined ROM entry.
  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  logic [127:0] sub_s;
  logic [127:0] state_d;
  logic [127:0] state_q;
  logic         valid_d;
  logic         valid_q;

  // Substitute all 16 byte lanes independently, preserving byte positions.
  always_comb begin
    sub_s = 128'h0;
    for (int k = 0; k < 16; k++) begin
      sub_s[8*k +: 8] = inv_sbox_byte(state[8*k +: 8]);
    end
  end

  // Next state: capture a new result when valid, otherwise hold the last one.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    if (in_valid) begin
      state_d = sub_s;
      valid_d = 1'b1;
    end else begin
      state_d = state_q;
      valid_d = 1'b0;
    end
  end

  // Output registers; asynchronous reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 128'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  assign state_out = state_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Self-checking bench for aes_inv_sub_bytes. The reference S-box is built
// arithmetically (GF(2^8) inverse plus affine map), independent of any table.
module tb_aes_inv_sub_bytes;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] state;
  logic [127:0] state_out;
  logic         out_valid;

  int n_total;
  int n_pass;

  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  typedef struct {
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  aes_inv_sub_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .state     (state),
    .state_out (state_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic       hi;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [127:0] model_word(input logic [127:0] st);
    logic [127:0] r;
    r = 128'h0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_m[st[8*k +: 8]];
    return r;
  endfunction

  task automatic build_model();
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      b = inv;
      s = b ^ rotl1(b) ^ rotl1(rotl1(b)) ^ rotl1(rotl1(rotl1(b))) ^
          rotl1(rotl1(rotl1(rotl1(b)))) ^ 8'h63;
      fwd_m[x] = s;
      inv_m[s] = 8'(x);
    end
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic [127:0] st, input logic v);
    @(negedge clk);
    state = st;
    in_valid = v;
  endtask

  initial begin
    logic [127:0] rs [5];
    logic [127:0] exp_q;
    logic         exp_v;
    logic [127:0] a_st;
    logic [127:0] w;
    logic         ok_fwd;
    logic [7:0]   vb;

    n_total = 0;
    n_pass = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    state = 128'h0;
    build_model();

    vecs[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{{16{8'h63}}, {16{8'h00}}};
    vecs[2] = '{{16{8'h00}}, {16{8'h52}}};
    vecs[3] = '{{16{8'hff}}, {16{8'h7d}}};
    vecs[4] = '{128'h7a9f102789d5f50b2beffd9f3dca4ea7, 128'hbd6e7c3df2b5779e0b61216e8b10b689};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", state_out, 128'h0);
    check("reset_valid", {127'h0, out_valid}, 128'h0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].st, 1'b1);
      drive(128'h0, 1'b0);
      check($sformatf("table%0d_out", i), state_out, vecs[i].exp);
      check($sformatf("table%0d_model", i), state_out, model_word(vecs[i].st));
      check($sformatf("table%0d_valid", i), {127'h0, out_valid}, 128'h1);
    end
    @(negedge clk);
    check("idle_valid", {127'h0, out_valid}, 128'h0);
    check("idle_hold", state_out, vecs[4].exp);

    // Streaming: five back-to-back states
    for (int i = 0; i < 5; i++) rs[i] = {$urandom, $urandom, $urandom, $urandom};
    drive(rs[0], 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("stream%0d_out", i - 1), state_out, model_word(rs[i-1]));
      check($sformatf("stream%0d_valid", i - 1), {127'h0, out_valid}, 128'h1);
      if (i < 5) state = rs[i];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check("stream_end_valid", {127'h0, out_valid}, 128'h0);
    check("stream_end_hold", state_out, model_word(rs[4]));

    // Random stream with random valid, tracked by the model
    exp_q = state_out;
    exp_v = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("rand_out", state_out, exp_q);
        check("rand_valid", {127'h0, out_valid}, {127'h0, exp_v});
      end
      a_st = {$urandom, $urandom, $urandom, $urandom};
      state = a_st;
      in_valid = 1'($urandom_range(0, 1));
      exp_v = in_valid;
      if (in_valid) exp_q = model_word(a_st);
    end
    @(negedge clk);
    check("rand_out_last", state_out, exp_q);
    in_valid = 1'b0;

    // Exhaustive byte sweep, all lanes replicated
    for (int v = 0; v < 256; v++) begin
      vb = 8'(v);
      drive({16{vb}}, 1'b1);
      drive(128'h0, 1'b0);
      check($sformatf("sweep_%02h", v), state_out, {16{inv_m[v]}});
      w = state_out;
      ok_fwd = 1'b1;
      for (int k = 0; k < 16; k++) if (fwd_m[w[8*k +: 8]] != vb) ok_fwd = 1'b0;
      check($sformatf("roundtrip_%02h", v), {127'h0, ok_fwd}, 128'h1);
    end

    // Sampling only at the edge: change input between edges
    drive(vecs[0].st, 1'b1);
    @(posedge clk);
    #1;
    state = vecs[4].st;
    in_valid = 1'b0;
    @(negedge clk);
    check("edge_sample", state_out, vecs[0].exp);

    // Asynchronous reset mid-cycle with nonzero output and an in-flight input
    drive(vecs[4].st, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", state_out, 128'h0);
    check("async_rst_valid", {127'h0, out_valid}, 128'h0);
    repeat (3) @(negedge clk);
    check("rst_held_out", state_out, 128'h0);
    check("rst_held_valid", {127'h0, out_valid}, 128'h0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_pulse", {127'h0, out_valid}, 128'h0);
    check("post_rst_out", state_out, 128'h0);

    // Input accepted on the first edge after release
    rst_n = 1'b0;
    @(negedge clk);
    state = vecs[2].st;
    in_valid = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("first_edge_out", state_out, vecs[2].exp);
    check("first_edge_valid", {127'h0, out_valid}, 128'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
